// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: state-based datapath controls,
// illegal-opcode pulse and a retired-instruction counter.
module multicycle_control #(
  parameter int ENABLE_ADDI = 1,
  parameter int ENABLE_JUMP = 1,
  parameter int MEM_WAIT    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             alu_src_a,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t stateQ, stateD;
  logic   memRdy;
  logic   retire;

  assign memRdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign state  = stateQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= FETCH;
      instr_count <= '0;
    end else begin
      stateQ <= stateD;
      if (retire) instr_count <= instr_count + CNT_ONE;
    end
  end

  always_comb begin
    stateD        = stateQ;
    retire        = 1'b0;
    illegal       = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    case (stateQ)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // rst_n gating keeps the IR/PC strobes quiet while reset holds FETCH
        ir_write  = memRdy & rst_n;
        pc_write  = memRdy & rst_n;
        if (memRdy) stateD = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: stateD = MEMADR;
          OP_R:         stateD = EXEC;
          OP_BEQ:       stateD = BRANCH;
          OP_ADDI: begin
            if (ENABLE_ADDI != 0) stateD = ADDIEX;
            else begin
              stateD  = FETCH;
              illegal = 1'b1;
            end
          end
          OP_J: begin
            if (ENABLE_JUMP != 0) stateD = JUMP;
            else begin
              stateD  = FETCH;
              illegal = 1'b1;
            end
          end
          default: begin
            stateD  = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        stateD    = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (memRdy) stateD = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        stateD     = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (memRdy) begin
          retire = 1'b1;
          stateD = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        stateD    = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        stateD    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        stateD        = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        stateD    = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        stateD    = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        stateD    = FETCH;
      end
      default: stateD = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle state/control
// entries are queued per instruction and checked at the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic iord, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a;
  logic reg_write, reg_dst, pc_write, pc_write_cond, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
  logic [15:0] instr_count;

  logic j_iord, j_mem_read, j_mem_write, j_mem_to_reg, j_ir_write, j_alu_src_a;
  logic j_reg_write, j_reg_dst, j_pc_write, j_pc_write_cond, j_illegal;
  logic [1:0] j_pc_source, j_alu_src_b, j_alu_op;
  logic [3:0] j_state;
  logic [15:0] j_instr_count;

  logic c_iord, c_mem_read, c_mem_write, c_mem_to_reg, c_ir_write, c_alu_src_a;
  logic c_reg_write, c_reg_dst, c_pc_write, c_pc_write_cond, c_illegal;
  logic [1:0] c_pc_source, c_alu_src_b, c_alu_op;
  logic [3:0] c_state;
  logic [3:0] c_instr_count;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .alu_src_a(alu_src_a), .reg_write(reg_write), .reg_dst(reg_dst),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  multicycle_control #(.ENABLE_JUMP(0)) dutNoJump (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .iord(j_iord), .mem_read(j_mem_read), .mem_write(j_mem_write), .mem_to_reg(j_mem_to_reg),
    .ir_write(j_ir_write), .alu_src_a(j_alu_src_a), .reg_write(j_reg_write), .reg_dst(j_reg_dst),
    .pc_write(j_pc_write), .pc_write_cond(j_pc_write_cond), .pc_source(j_pc_source),
    .alu_src_b(j_alu_src_b), .alu_op(j_alu_op), .state(j_state), .illegal(j_illegal),
    .instr_count(j_instr_count)
  );

  multicycle_control #(.MEM_WAIT(0), .CNT_W(4)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .iord(c_iord), .mem_read(c_mem_read), .mem_write(c_mem_write), .mem_to_reg(c_mem_to_reg),
    .ir_write(c_ir_write), .alu_src_a(c_alu_src_a), .reg_write(c_reg_write), .reg_dst(c_reg_dst),
    .pc_write(c_pc_write), .pc_write_cond(c_pc_write_cond), .pc_source(c_pc_source),
    .alu_src_b(c_alu_src_b), .alu_op(c_alu_op), .state(c_state), .illegal(c_illegal),
    .instr_count(c_instr_count)
  );

  logic [15:0] ctrl;
  assign ctrl = {iord, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write,
                 reg_dst, pc_write, pc_write_cond, pc_source, alu_src_b, alu_op};

  typedef struct {
    logic        rdy;
    logic [3:0]  st;
    logic        ill;
    int unsigned cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned expCount = 0;
  int unsigned tests = 0;
  int unsigned failed = 0;
  bit          checkJ = 1'b0;
  bit          syncC = 1'b0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit order matches the ctrl concatenation above.
  function automatic logic [15:0] ctrlFor(input logic [3:0] st, input logic rdy);
    logic [15:0] c;
    c = '0;
    case (st)
      4'd0:  begin c[14] = 1'b1; c[3:2] = 2'b01; c[11] = rdy; c[7] = rdy; end
      4'd1:  c[3:2] = 2'b11;
      4'd2:  begin c[10] = 1'b1; c[3:2] = 2'b10; end
      4'd3:  begin c[15] = 1'b1; c[14] = 1'b1; end
      4'd4:  begin c[9] = 1'b1; c[12] = 1'b1; end
      4'd5:  begin c[15] = 1'b1; c[13] = 1'b1; end
      4'd6:  begin c[10] = 1'b1; c[1:0] = 2'b10; end
      4'd7:  begin c[9] = 1'b1; c[8] = 1'b1; end
      4'd8:  begin c[10] = 1'b1; c[1:0] = 2'b01; c[6] = 1'b1; c[5:4] = 2'b01; end
      4'd9:  begin c[10] = 1'b1; c[3:2] = 2'b10; end
      4'd10: c[9] = 1'b1;
      4'd11: begin c[7] = 1'b1; c[5:4] = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input logic rdy, input logic [3:0] st, input logic ill, input logic fin);
    exp_t e;
    e.rdy = rdy; e.st = st; e.ill = ill; e.cnt = expCount;
    q.push_back(e);
    if (fin) expCount++;
  endtask

  task automatic drain();
    exp_t e;
    logic [3:0] c4;
    while (q.size() != 0) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      @(negedge clk);
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'(ctrl), 32'(ctrlFor(e.st, e.rdy)));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("count", 32'(instr_count), 32'(e.cnt[15:0]));
      if (checkJ) begin
        chk("noJumpPcSrc", 32'(j_pc_source == 2'b10), 32'd0);
        if (e.st == 4'd1) chk("noJumpIllegal", 32'(j_illegal), 32'd1);
      end
      if (syncC) begin
        c4 = e.cnt[3:0];
        chk("narrowState", 32'(c_state), 32'(e.st));
        chk("narrowCount", 32'(c_instr_count), 32'(c4));
        chk("narrowPcWc", 32'(c_pc_write_cond), 32'(e.st == 4'd8));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic doInstr(input logic [5:0] op, input int unsigned stall);
    opcode = op;
    push(1'b1, 4'd0, 1'b0, 1'b0);
    case (op)
      LW: begin
        push(1'b1, 4'd1, 1'b0, 1'b0); push(1'b1, 4'd2, 1'b0, 1'b0);
        repeat (stall) push(1'b0, 4'd3, 1'b0, 1'b0);
        push(1'b1, 4'd3, 1'b0, 1'b0); push(1'b1, 4'd4, 1'b0, 1'b1);
      end
      SW: begin
        push(1'b1, 4'd1, 1'b0, 1'b0); push(1'b1, 4'd2, 1'b0, 1'b0);
        repeat (stall) push(1'b0, 4'd5, 1'b0, 1'b0);
        push(1'b1, 4'd5, 1'b0, 1'b1);
      end
      RT:   begin push(1'b1, 4'd1, 1'b0, 1'b0); push(1'b1, 4'd6, 1'b0, 1'b0); push(1'b1, 4'd7, 1'b0, 1'b1); end
      BEQ:  begin push(1'b1, 4'd1, 1'b0, 1'b0); push(1'b1, 4'd8, 1'b0, 1'b1); end
      ADDI: begin push(1'b1, 4'd1, 1'b0, 1'b0); push(1'b1, 4'd9, 1'b0, 1'b0); push(1'b1, 4'd10, 1'b0, 1'b1); end
      JMP:  begin push(1'b1, 4'd1, 1'b0, 1'b0); push(1'b1, 4'd11, 1'b0, 1'b1); end
      default: push(1'b1, 4'd1, 1'b1, 1'b0);
    endcase
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = LW;
    mem_ready = 1'b1;
    #3;
    chk("rstState", 32'(state), 32'd0);
    chk("rstIrWrite", 32'(ir_write), 32'd0);
    chk("rstPcWrite", 32'(pc_write), 32'd0);
    chk("rstMemRead", 32'(mem_read), 32'd1);
    chk("rstAluSrcB", 32'(alu_src_b), 32'd1);
    chk("rstCount", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    push(1'b0, 4'd0, 1'b0, 1'b0);
    doInstr(LW, 0);
    doInstr(SW, 3);
    doInstr(RT, 0);
    doInstr(ADDI, 0);
    doInstr(BEQ, 0);
    doInstr(6'b111111, 0);
    doInstr(LW, 2);
    checkJ = 1'b1;
    doInstr(JMP, 0);
    checkJ = 1'b0;

    // R-type aborted by an asynchronous reset while in EXEC
    opcode = RT;
    push(1'b1, 4'd0, 1'b0, 1'b0);
    push(1'b1, 4'd1, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("execState", 32'(state), 32'd6);
    chk("execCount", 32'(instr_count), 32'(expCount[15:0]));
    #2 rst_n = 1'b0;
    #1;
    chk("abortState", 32'(state), 32'd0);
    chk("abortCount", 32'(instr_count), 32'd0);
    chk("abortRegWrite", 32'(reg_write), 32'd0);
    @(posedge clk); #1;
    chk("heldState", 32'(state), 32'd0);
    rst_n = 1'b1;
    expCount = 0;

    syncC = 1'b1;
    for (int i = 0; i < 16; i++) doInstr(BEQ, 0);
    syncC = 1'b0;
    chk("wideCount16", 32'(instr_count), 32'd16);
    chk("narrowWrap", 32'(c_instr_count), 32'd0);

    // MEM_WAIT=0 instance must ignore a low mem_ready in FETCH
    mem_ready = 1'b0;
    @(negedge clk);
    chk("waitFetch", 32'(state), 32'd0);
    chk("noWaitFetch", 32'(c_state), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("waitStall", 32'(state), 32'd0);
    chk("noWaitDecode", 32'(c_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ENABLE_ADDI, default 1, meaning: 1 = ADDI (opcode 001000) is decoded; 0 = ADDI is treated as illegal.
REQ-002 SHALL have parameter ENABLE_JUMP, default 1, meaning: 1 = J (opcode 000010) is decoded; 0 = J is treated as illegal.
REQ-003 SHALL have parameter MEM_WAIT, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as constant 1.
REQ-004 SHALL have parameter CNT_W, default 16, meaning: width of the retired-instruction counter.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-009 mem_ready  in  1  memory access complete this cycle.
REQ-010 iord, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, pc_write, pc_write_cond  out  1 each  datapath controls.
REQ-011 pc_source, alu_src_b, alu_op  out  2 each  datapath mux and ALU class selects.
REQ-012 state  out  4  current state encoding, for debug.
REQ-013 illegal  out  1  one-cycle pulse when an undecoded opcode is seen.
REQ-014 instr_count  out  CNT_W  number of retired instructions.

Function
REQ-015 States and encodings SHALL be:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXEC=6, RTYPEWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Codes 12-15 are unused.
REQ-016 Outputs SHALL be a function of state only, except for the mem_ready gating in REQ-017. Any control not listed for a state is 0.
REQ-017 FETCH SHALL drive mem_read=1, alu_src_b=01, alu_op=00, ir_write=pc_write=mem_ready. It stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-018 DECODE SHALL drive alu_src_b=11, alu_op=00. Next state by opcode:
- 100011 (LW) or 101011 (SW) -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 001000 -> ADDIEX (if enabled)
- 000010 -> JUMP (if enabled)
- anything else -> FETCH, with illegal=1 for that cycle
REQ-019 MEMADR SHALL drive alu_src_a=1, alu_src_b=10. Next state: MEMRD for LW, MEMWR for SW.
REQ-020 MEMRD SHALL drive iord=1, mem_read=1. It waits for mem_ready, then goes to MEMWB.
REQ-021 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-022 MEMWR SHALL drive iord=1, mem_write=1. It waits for mem_ready, then goes to FETCH.
REQ-023 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to RTYPEWB.
REQ-024 RTYPEWB SHALL drive reg_write=1, reg_dst=1, then go to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-026 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB.
REQ-027 ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-028 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-029 Latency in cycles, with MEM_WAIT=0 or mem_ready held high: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
REQ-030 instr_count SHALL increment by 1 on the final cycle of each instruction: MEMWB, MEMWR with mem_ready, RTYPEWB, BRANCH, ADDIWB, JUMP. It wraps modulo 2^CNT_W. Illegal opcodes are not counted.
REQ-031 An unused state code SHALL drive all controls to 0 and go to FETCH on the next edge.
REQ-032 Opcode SHALL be sampled only in DECODE and MEMADR; changes at other times are ignored.

Reset
REQ-033 While rst_n=0, state SHALL be FETCH asynchronously and instr_count=0, with all controls at FETCH values and ir_write=pc_write=0.
REQ-034 Reset asserted mid-instruction SHALL abort it with no further register write or memory write, and without incrementing the counter.
REQ-035 After rst_n rises, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-036 LW (100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count 0->1.
REQ-037 SW with mem_ready low for 3 cycles in MEMWR -> state held at 5 with mem_write=1 for 4 cycles, then FETCH; no reg_write at any point.
REQ-038 Opcode 111111 in DECODE -> illegal=1 for exactly one cycle, next state 0, instr_count unchanged.
REQ-039 ENABLE_JUMP=0, opcode 000010 -> illegal pulse, no pc_source=10 at any point; ENABLE_JUMP=1 -> states 0,1,11,0 with pc_write=1 in state 11.
REQ-040 rst_n driven low in EXEC (state 6), asynchronously between edges -> state=0 immediately with no RTYPEWB; instr_count=0.
REQ-041 CNT_W=4, 16 BEQ instructions -> instr_count wraps to 0, with pc_write_cond=1 only in state 8.
